// File: rtl/clk_switch_monitor.sv
// -----------------------------------------------------------------------------
// clk_switch_monitor
//   Receive-side checker for a glitch-free clock switch. The switched clock
//   (mon_clk) is synchronized into the free-running reference domain (clk),
//   its period is measured in reference cycles, and runt phases, a stopped
//   clock and frequency changes are flagged.
//
// Ports
//   clk        in   1      reference clock, > 2x mon_clk frequency
//   rstn       in   1      synchronous reset, active low
//   mon_clk    in   1      monitored clock, asynchronous to clk
//   en         in   1      1 = monitor; 0 = return to IDLE, clear counters
//   period     out  CNT_W  last measured period (reference cycles, rise to rise)
//   period_vld out  1      1-cycle pulse when period is updated
//   glitch     out  1      1-cycle pulse: a phase shorter than MIN_HALF samples
//   freq_chg   out  1      1-cycle pulse: period moved by more than TOL
//   stuck      out  1      level: no mon_clk edge for TIMEOUT cycles
//   ovf        out  1      sticky: period counter saturated
//   state      out  3      FSM state (IDLE=0 ACQ=1 MEAS=2 LOCK=3 LOST=4)
// -----------------------------------------------------------------------------
module clk_switch_monitor #(
    parameter int CNT_W    = 8,
    parameter int MIN_HALF = 2,
    parameter int TIMEOUT  = 64,
    parameter int TOL      = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mon_clk,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             glitch,
    output logic             freq_chg,
    output logic             stuck,
    output logic             ovf,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACQ  = 3'd1,
        MEAS = 3'd2,
        LOCK = 3'd3,
        LOST = 3'd4
    } state_e;

    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = '1;
    localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]    MIN_V    = (CNT_W + 1)'(MIN_HALF);
    localparam logic [CNT_W:0]    TOL_V    = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]    ONE_V    = (CNT_W + 1)'(1);

    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    state_e            state_q;
    logic [CNT_W-1:0]  period_q;
    logic              period_vld_q, glitch_q, freq_chg_q, stuck_q, ovf_q;

    logic              rise, fall, any_edge, timeout, ph_short, per_sat, freq_big;
    logic [CNT_W-1:0]  period_new;
    logic [CNT_W:0]    new_w, old_w, diff_abs;

    // NOTE: every signal written here gets a value before any branch, so no
    // latch can be inferred.
    always_comb begin
        rise     = s2_q & ~s3_q;
        fall     = ~s2_q & s3_q;
        any_edge = rise | fall;
        timeout  = (idle_cnt_q == TO_LAST);

        per_sat    = (per_cnt_q == CNT_MAX);
        period_new = per_sat ? CNT_MAX : per_cnt_q + 1'b1;
        per_cnt_d  = rise ? '0 : period_new;

        ph_cnt_d   = any_edge ? '0 : ((ph_cnt_q == CNT_MAX) ? CNT_MAX : ph_cnt_q + 1'b1);
        idle_cnt_d = any_edge ? '0 : ((idle_cnt_q == IDLE_MAX) ? IDLE_MAX : idle_cnt_q + 1'b1);

        // Phase length including the edge cycle itself, one bit wider so it cannot wrap.
        ph_short = (({1'b0, ph_cnt_q} + ONE_V) < MIN_V);

        // Unsigned absolute difference, one bit wider than the counters.
        new_w    = {1'b0, period_new};
        old_w    = {1'b0, period_q};
        diff_abs = (new_w >= old_w) ? (new_w - old_w) : (old_w - new_w);
        freq_big = (diff_abs > TOL_V);
    end

    // NOTE: sequential state uses non-blocking assignments only, and the reset
    // is sampled on the clock edge (synchronous), not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            per_cnt_q    <= '0;
            ph_cnt_q     <= '0;
            idle_cnt_q   <= '0;
            state_q      <= IDLE;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            glitch_q     <= 1'b0;
            freq_chg_q   <= 1'b0;
            stuck_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            s1_q <= mon_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;

            // Pulse outputs default low; set only in the cycle after their event.
            period_vld_q <= 1'b0;
            glitch_q     <= 1'b0;
            freq_chg_q   <= 1'b0;

            if (!en) begin
                // Disable has priority over any edge seen in the same cycle.
                state_q    <= IDLE;
                per_cnt_q  <= '0;
                ph_cnt_q   <= '0;
                idle_cnt_q <= '0;
                stuck_q    <= 1'b0;
                ovf_q      <= 1'b0;
            end else begin
                per_cnt_q  <= per_cnt_d;
                ph_cnt_q   <= ph_cnt_d;
                idle_cnt_q <= idle_cnt_d;

                case (state_q)
                    IDLE: state_q <= ACQ;
                    ACQ: begin
                        // A rise beats a coincident timeout.
                        if (rise) begin
                            state_q <= MEAS;
                        end else if (timeout) begin
                            state_q <= LOST;
                            stuck_q <= 1'b1;
                        end
                    end
                    MEAS, LOCK: begin
                        if (any_edge && ph_short) begin
                            glitch_q <= 1'b1;
                        end
                        if (rise) begin
                            period_q     <= period_new;
                            period_vld_q <= 1'b1;
                            if (per_sat) begin
                                ovf_q <= 1'b1;
                            end
                            // The first capture after MEAS has no valid reference.
                            if (state_q == LOCK && freq_big) begin
                                freq_chg_q <= 1'b1;
                            end
                            state_q <= LOCK;
                        end else if (timeout) begin
                            state_q <= LOST;
                            stuck_q <= 1'b1;
                        end
                    end
                    LOST: begin
                        if (rise) begin
                            state_q <= MEAS;
                            stuck_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign glitch     = glitch_q;
    assign freq_chg   = freq_chg_q;
    assign stuck      = stuck_q;
    assign ovf        = ovf_q;
    assign state      = state_q;

endmodule
